// File: rtl/leaf_bridge_pkg.sv
// Shared constants, helper function and channel-slice macro for the leaf port bridge.
// The optional statistics block is enabled by defining LEAF_BRIDGE_STATS_EN.
package leaf_bridge_pkg;

    localparam int LB_PAYLOAD_BITS  = 32;
    localparam int LB_NUM_IN_PORTS  = 2;
    localparam int LB_NUM_OUT_PORTS = 4;
    localparam int LB_FIFO_DEPTH    = 4;
    localparam int LB_CNT_BITS      = 16;

    // Ceiling log2 for elaboration-time sizing; lb_clog2(1) = 0.
    function automatic int lb_clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 32'sd1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                res = res + 32'sd1;
                rem = rem >>> 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// Select channel idx of a flat bus made of w-bit lanes.
`ifndef LB_SLICE
`define LB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

// File: rtl/leaf_chan_fifo.sv
// Single-clock channel FIFO with registered head data, registered full/empty,
// producer ack taken only from registered state and a synchronous flush.
module leaf_chan_fifo
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS = LB_PAYLOAD_BITS,
    parameter int FIFO_DEPTH   = LB_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    din_vld,
    output logic                    din_ack,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_ack,
    output logic                    empty,
    output logic                    full
);

    localparam int PTR_W = lb_clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

    logic [PAYLOAD_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r, wr_ptr_nxt_s;
    logic [PTR_W-1:0]        rd_ptr_r, rd_ptr_nxt_s, rd_ptr_inc_s;
    logic [CNT_W-1:0]        count_r, count_nxt_s;
    logic                    empty_r, empty_nxt_s;
    logic                    full_r, full_nxt_s;
    logic [PAYLOAD_BITS-1:0] head_r, head_nxt_s;
    logic                    push_s, pop_s;

    // A full FIFO refuses the push, so simultaneous push+pop at full is pop only.
    assign push_s       = din_vld & ~full_r;
    assign pop_s        = dout_ack & ~empty_r;
    assign rd_ptr_inc_s = rd_ptr_r + PTR_ONE_C;

    // Next-state for pointers, occupancy, flags and the registered head word.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_r;
        empty_nxt_s  = empty_r;
        full_nxt_s   = full_r;
        if (flush) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            count_nxt_s  = '0;
            head_nxt_s   = '0;
            empty_nxt_s  = 1'b1;
            full_nxt_s   = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_inc_s;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE_C;
                2'b01:   count_nxt_s = count_r - CNT_ONE_C;
                default: count_nxt_s = count_r;
            endcase
            // Head tracks the oldest word; a push into an empty FIFO becomes the head,
            // and a pop of the last word hands over to a same-cycle push if present.
            if (pop_s) begin
                if (count_r == CNT_ONE_C) begin
                    if (push_s) begin
                        head_nxt_s = din;
                    end else begin
                        head_nxt_s = '0;
                    end
                end else begin
                    head_nxt_s = mem_r[rd_ptr_inc_s];
                end
            end else if (push_s && empty_r) begin
                head_nxt_s = din;
            end else begin
                head_nxt_s = head_r;
            end
            empty_nxt_s = (count_nxt_s == '0);
            full_nxt_s  = (count_nxt_s == DEPTH_C);
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            empty_r  <= empty_nxt_s;
            full_r   <= full_nxt_s;
        end
    end

    // Storage array; a push during flush is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Ack is held high through a flush so the producer is never blocked by it.
    assign din_ack  = ~full_r | flush;
    assign dout     = head_r;
    assign dout_vld = ~empty_r;
    assign empty    = empty_r;
    assign full     = full_r;

endmodule

// File: rtl/leaf_port_bridge.sv
// Buffering bridge between a leaf interface and a user operator: one FIFO per
// inbound and outbound channel, packed status, and optional per-channel push
// counters enabled by defining LEAF_BRIDGE_STATS_EN.
module leaf_port_bridge
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS  = LB_PAYLOAD_BITS,
    parameter int NUM_IN_PORTS  = LB_NUM_IN_PORTS,
    parameter int NUM_OUT_PORTS = LB_NUM_OUT_PORTS,
    parameter int FIFO_DEPTH    = LB_FIFO_DEPTH,
    parameter int CNT_BITS      = LB_CNT_BITS
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    usr_in_data,
    output logic [NUM_IN_PORTS-1:0]                 usr_in_vld,
    input  logic [NUM_IN_PORTS-1:0]                 usr_in_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   usr_out_data,
    input  logic [NUM_OUT_PORTS-1:0]                usr_out_vld,
    output logic [NUM_OUT_PORTS-1:0]                usr_out_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
`ifdef LEAF_BRIDGE_STATS_EN
    output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS-1:0] xfer_cnt,
`endif
    output logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]   fifo_empty,
    output logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]   fifo_full
);

    localparam int NUM_CH = NUM_IN_PORTS + NUM_OUT_PORTS;

    // Inbound channels occupy the low status bits.
    for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
        leaf_chan_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .FIFO_DEPTH   (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .din      (`LB_SLICE(dout_leaf_interface2user, gi, PAYLOAD_BITS)),
            .din_vld  (vld_interface2user[gi]),
            .din_ack  (ack_user2interface[gi]),
            .dout     (`LB_SLICE(usr_in_data, gi, PAYLOAD_BITS)),
            .dout_vld (usr_in_vld[gi]),
            .dout_ack (usr_in_ack[gi]),
            .empty    (fifo_empty[gi]),
            .full     (fifo_full[gi])
        );
    end

    for (genvar go = 0; go < NUM_OUT_PORTS; go++) begin : g_out
        leaf_chan_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .FIFO_DEPTH   (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .din      (`LB_SLICE(usr_out_data, go, PAYLOAD_BITS)),
            .din_vld  (usr_out_vld[go]),
            .din_ack  (usr_out_ack[go]),
            .dout     (`LB_SLICE(din_leaf_user2interface, go, PAYLOAD_BITS)),
            .dout_vld (vld_user2interface[go]),
            .dout_ack (ack_interface2user[go]),
            .empty    (fifo_empty[NUM_IN_PORTS+go]),
            .full     (fifo_full[NUM_IN_PORTS+go])
        );
    end

`ifdef LEAF_BRIDGE_STATS_EN
    localparam logic [CNT_BITS-1:0] CNT_MAX_C = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE_C = CNT_BITS'(1);

    logic [NUM_CH-1:0] push_s;

    // Producer-side handshakes, same channel order as the status vectors.
    assign push_s = {usr_out_vld & usr_out_ack, vld_interface2user & ack_user2interface};

    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_cnt
        logic [CNT_BITS-1:0] cnt_r;

        // Saturating push counter, cleared together with the FIFOs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_r <= '0;
            end else if (flush) begin
                cnt_r <= '0;
            end else if (push_s[gc] && (cnt_r != CNT_MAX_C)) begin
                cnt_r <= cnt_r + CNT_ONE_C;
            end
        end

        assign xfer_cnt[gc*CNT_BITS +: CNT_BITS] = cnt_r;
    end
`endif

endmodule

// File: tb/tb_leaf_port_bridge.sv
// Self-checking bench for leaf_port_bridge: per-channel scoreboard queues plus
// a vector table for the fill/drain sequence and directed corner-case sequences.
module tb_leaf_port_bridge;

    localparam int PB    = 32;
    localparam int NIN   = 2;
    localparam int NOUT  = 4;
    localparam int NCH   = NIN + NOUT;
    localparam int DEPTH = 4;
    localparam int CB    = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [NIN*PB-1:0]    dout_leaf_interface2user;
    logic [NIN-1:0]       vld_interface2user;
    logic [NIN-1:0]       ack_user2interface;
    logic [NIN*PB-1:0]    usr_in_data;
    logic [NIN-1:0]       usr_in_vld;
    logic [NIN-1:0]       usr_in_ack;
    logic [NOUT*PB-1:0]   usr_out_data;
    logic [NOUT-1:0]      usr_out_vld;
    logic [NOUT-1:0]      usr_out_ack;
    logic [NOUT*PB-1:0]   din_leaf_user2interface;
    logic [NOUT-1:0]      vld_user2interface;
    logic [NOUT-1:0]      ack_interface2user;
    logic [NCH-1:0]       fifo_empty;
    logic [NCH-1:0]       fifo_full;
`ifdef LEAF_BRIDGE_STATS_EN
    logic [NCH*CB-1:0]    xfer_cnt;
`endif

    leaf_port_bridge #(
        .PAYLOAD_BITS  (PB),
        .NUM_IN_PORTS  (NIN),
        .NUM_OUT_PORTS (NOUT),
        .FIFO_DEPTH    (DEPTH),
        .CNT_BITS      (CB)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .flush                    (flush),
        .dout_leaf_interface2user (dout_leaf_interface2user),
        .vld_interface2user       (vld_interface2user),
        .ack_user2interface       (ack_user2interface),
        .usr_in_data              (usr_in_data),
        .usr_in_vld               (usr_in_vld),
        .usr_in_ack               (usr_in_ack),
        .usr_out_data             (usr_out_data),
        .usr_out_vld              (usr_out_vld),
        .usr_out_ack              (usr_out_ack),
        .din_leaf_user2interface  (din_leaf_user2interface),
        .vld_user2interface       (vld_user2interface),
        .ack_interface2user       (ack_interface2user),
`ifdef LEAF_BRIDGE_STATS_EN
        .xfer_cnt                 (xfer_cnt),
`endif
        .fifo_empty               (fifo_empty),
        .fifo_full                (fifo_full)
    );

    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_err = 0;
    bit             mon_en = 1'b0;
    logic [NCH-1:0] prod_xfer = '0;
    logic [PB-1:0]  sb_q [NCH][$];

    task automatic chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, models each channel as a bounded queue.
    always @(negedge clk) begin
        logic          pv, pa, cv, ca;
        logic [PB-1:0] pd, cd;
        int            o;
        if (reset) begin
            for (int c = 0; c < NCH; c++) sb_q[c].delete();
            prod_xfer = '0;
        end else if (mon_en) begin
            for (int c = 0; c < NCH; c++) begin
                if (c < NIN) begin
                    pv = vld_interface2user[c];
                    pa = ack_user2interface[c];
                    pd = dout_leaf_interface2user[c*PB +: PB];
                    cv = usr_in_vld[c];
                    ca = usr_in_ack[c];
                    cd = usr_in_data[c*PB +: PB];
                end else begin
                    o  = c - NIN;
                    pv = usr_out_vld[o];
                    pa = usr_out_ack[o];
                    pd = usr_out_data[o*PB +: PB];
                    cv = vld_user2interface[o];
                    ca = ack_interface2user[o];
                    cd = din_leaf_user2interface[o*PB +: PB];
                end
                prod_xfer[c] = pv & pa;
                if (flush) begin
                    chk($sformatf("ch%0d ack in flush", c), 32'(pa), 32'd1);
                    sb_q[c].delete();
                end else begin
                    chk($sformatf("ch%0d vld", c), 32'(cv), 32'(sb_q[c].size() != 0));
                    chk($sformatf("ch%0d ack", c), 32'(pa), 32'(sb_q[c].size() < DEPTH));
                    chk($sformatf("ch%0d empty", c), 32'(fifo_empty[c]), 32'(sb_q[c].size() == 0));
                    chk($sformatf("ch%0d full", c), 32'(fifo_full[c]), 32'(sb_q[c].size() == DEPTH));
                    if (cv && ca) begin
                        if (sb_q[c].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL ch%0d unexpected word: actual %0h required none", c, cd);
                        end else begin
                            chk($sformatf("ch%0d data", c), cd, sb_q[c].pop_front());
                        end
                    end
                    if (pv && pa) sb_q[c].push_back(pd);
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          vld;
        logic          uack;
        logic [PB-1:0] data;
        logic          e_ack;
        logic          e_vld;
        logic          e_full;
        logic          e_empty;
        logic [PB-1:0] e_data;
    } vec_t;

    vec_t tbl [11];

    task automatic idle();
        vld_interface2user = '0;
        usr_in_ack         = '0;
        usr_out_vld        = '0;
        ack_interface2user = '0;
        flush              = 1'b0;
    endtask

    initial begin
        // Fill inbound ch0 without consumer ack, then drain; values seen before each edge.
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'hA000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'hA000_0002, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA000_0001};
        tbl[3]  = '{1'b1, 1'b0, 32'hA000_0003, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA000_0001};
        tbl[4]  = '{1'b1, 1'b0, 32'hA000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA000_0001};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'hA000_0001};
        tbl[6]  = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'hA000_0001};
        tbl[7]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'hA000_0002};
        tbl[8]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'hA000_0003};
        tbl[9]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'hA000_0004};
        tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

        reset = 1'b1;
        dout_leaf_interface2user = '0;
        usr_out_data = '0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst usr_in_vld", 32'(usr_in_vld), 32'd0);
        chk("rst vld_u2i", 32'(vld_user2interface), 32'd0);
        chk("rst ack_u2i", 32'(ack_user2interface), 32'h3);
        chk("rst usr_out_ack", 32'(usr_out_ack), 32'hF);
        chk("rst fifo_empty", 32'(fifo_empty), 32'h3F);
        chk("rst fifo_full", 32'(fifo_full), 32'h0);
        chk("rst in data", 32'(|usr_in_data), 32'd0);
        chk("rst out data", 32'(|din_leaf_user2interface), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Table: fill to full, ack drop, ordered drain.
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            vld_interface2user[0] = tbl[k].vld;
            dout_leaf_interface2user[PB-1:0] = tbl[k].data;
            usr_in_ack[0] = tbl[k].uack;
            @(negedge clk);
            chk($sformatf("tbl%0d ack", k), 32'(ack_user2interface[0]), 32'(tbl[k].e_ack));
            chk($sformatf("tbl%0d vld", k), 32'(usr_in_vld[0]), 32'(tbl[k].e_vld));
            chk($sformatf("tbl%0d full", k), 32'(fifo_full[0]), 32'(tbl[k].e_full));
            chk($sformatf("tbl%0d empty", k), 32'(fifo_empty[0]), 32'(tbl[k].e_empty));
            if (tbl[k].e_vld) chk($sformatf("tbl%0d data", k), usr_in_data[PB-1:0], tbl[k].e_data);
        end
        idle();

        // Pass-through on out ch3 with the interface always accepting.
        ack_interface2user[3] = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            usr_out_vld[3] = (i <= 16);
            usr_out_data[3*PB +: PB] = (i <= 16) ? 32'(i) : 32'h0;
            @(negedge clk);
            chk($sformatf("pt%0d ack", i), 32'(usr_out_ack[3]), 32'd1);
            if (i == 1) begin
                chk("pt1 no bypass", 32'(vld_user2interface[3]), 32'd0);
            end else begin
                chk($sformatf("pt%0d vld", i), 32'(vld_user2interface[3]), 32'd1);
                chk($sformatf("pt%0d data", i), din_leaf_user2interface[3*PB +: PB], 32'(i - 1));
            end
        end
        idle();

        // In ch1: push+pop attempted at full, then at empty.
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            vld_interface2user[1] = 1'b1;
            dout_leaf_interface2user[PB +: PB] = 32'hB000_0000 + 32'(i);
        end
        @(posedge clk); #1;
        dout_leaf_interface2user[PB +: PB] = 32'hB000_0005;
        usr_in_ack[1] = 1'b1;
        @(negedge clk);
        chk("full ack blocked", 32'(ack_user2interface[1]), 32'd0);
        chk("full flag", 32'(fifo_full[1]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after pop full", 32'(fifo_full[1]), 32'd0);
        chk("after pop head", usr_in_data[PB +: PB], 32'hB000_0002);
        @(posedge clk); #1;
        vld_interface2user[1] = 1'b0;
        @(negedge clk);
        chk("pushpop mid full", 32'(fifo_full[1]), 32'd0);
        chk("pushpop mid head", usr_in_data[PB +: PB], 32'hB000_0003);
        repeat (3) @(posedge clk);
        #1;
        usr_in_ack[1] = 1'b0;
        @(negedge clk);
        chk("drained empty", 32'(fifo_empty[1]), 32'd1);
        @(posedge clk); #1;
        vld_interface2user[1] = 1'b1;
        dout_leaf_interface2user[PB +: PB] = 32'hC000_0001;
        usr_in_ack[1] = 1'b1;
        @(posedge clk); #1;
        vld_interface2user[1] = 1'b0;
        usr_in_ack[1] = 1'b0;
        @(negedge clk);
        chk("empty pushpop vld", 32'(usr_in_vld[1]), 32'd1);
        chk("empty pushpop data", usr_in_data[PB +: PB], 32'hC000_0001);
        @(posedge clk); #1;
        usr_in_ack[1] = 1'b1;
        @(posedge clk); #1;
        idle();

        // Random traffic on all channels; producers hold data while stalled.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                if (c < NIN) begin
                    if (!(vld_interface2user[c] && !prod_xfer[c])) begin
                        vld_interface2user[c] = ($urandom_range(0, 3) != 0);
                        dout_leaf_interface2user[c*PB +: PB] = $urandom;
                    end
                    usr_in_ack[c] = ($urandom_range(0, 2) != 0);
                end else begin
                    if (!(usr_out_vld[c-NIN] && !prod_xfer[c])) begin
                        usr_out_vld[c-NIN] = ($urandom_range(0, 3) != 0);
                        usr_out_data[(c-NIN)*PB +: PB] = $urandom;
                    end
                    ack_interface2user[c-NIN] = ($urandom_range(0, 2) != 0);
                end
            end
        end
        @(posedge clk); #1;
        vld_interface2user = '0;
        usr_out_vld = '0;
        usr_in_ack = '1;
        ack_interface2user = '1;
        repeat (8) @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("random drained", 32'(fifo_empty), 32'h3F);

        // Flush with 3 words in in ch0, out ch0 full, and a push pending on in ch0.
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            vld_interface2user[0] = (i <= 3);
            dout_leaf_interface2user[PB-1:0] = 32'hD000_0000 + 32'(i);
            usr_out_vld[0] = 1'b1;
            usr_out_data[PB-1:0] = 32'hE000_0000 + 32'(i);
        end
        @(posedge clk); #1;
        usr_out_vld[0] = 1'b0;
        vld_interface2user[0] = 1'b1;
        dout_leaf_interface2user[PB-1:0] = 32'hD000_00FF;
        flush = 1'b1;
        @(negedge clk);
        chk("flush in0 ack", 32'(ack_user2interface[0]), 32'd1);
        chk("flush out0 ack", 32'(usr_out_ack[0]), 32'd1);
        chk("pre-flush out0 full", 32'(fifo_full[NIN]), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        vld_interface2user[0] = 1'b0;
        @(negedge clk);
        chk("flush empty", 32'(fifo_empty), 32'h3F);
        chk("flush full", 32'(fifo_full), 32'h0);
        chk("flush usr_in_vld", 32'(usr_in_vld), 32'd0);
        chk("flush vld_u2i", 32'(vld_user2interface), 32'd0);
        chk("flush acks", 32'({usr_out_ack, ack_user2interface}), 32'h3F);
`ifdef LEAF_BRIDGE_STATS_EN
        chk("flush xfer_cnt", 32'(|xfer_cnt), 32'd0);

        // Saturating counter on in ch0.
        usr_in_ack[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            vld_interface2user[0] = 1'b1;
            dout_leaf_interface2user[PB-1:0] = 32'hF000_0000 + 32'(i);
            if (i == 10) begin
                @(negedge clk);
                chk("xfer_cnt 10", 32'(xfer_cnt[CB-1:0]), 32'hA);
            end
        end
        @(posedge clk); #1;
        vld_interface2user[0] = 1'b0;
        @(negedge clk);
        chk("xfer_cnt sat", 32'(xfer_cnt[CB-1:0]), 32'hF);
        @(posedge clk); #1;
        idle();
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
